// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the branch hazard controller.
//   - br_haz select encodings driven to the branch-operand muxes
//   - RUN/HOLD stall FSM state type and the hold-count ceiling
//   - Tracker entry bit layout. An A entry is {is_load, rd, regwen, vld}
//     with vld at bit 0. An M entry is the same layout without the top
//     is_load bit, because a load that has reached M has its data on the
//     dmem path and is always forwardable.
package branch_hazard_ctrl_pkg;

  localparam logic [2:0] BR_HAZ_NONE   = 3'd0;
  localparam logic [2:0] BR_HAZ_ALU_A  = 3'd1;
  localparam logic [2:0] BR_HAZ_ALU_B  = 3'd2;
  localparam logic [2:0] BR_HAZ_DMEM_A = 3'd3;
  localparam logic [2:0] BR_HAZ_DMEM_B = 3'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_e;

  // Longest legal run of back-to-back stall cycles.
  localparam logic [1:0] HOLD_CNT_MAX = 2'd2;

  // Forwarding source reported by br_fwd_match.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_M = 1'b1;

  // Tracker entry field positions. The is_load bit sits at index REG_AW+2.
  localparam int TRK_VLD    = 0;
  localparam int TRK_REGWEN = 1;
  localparam int TRK_RD     = 2;

  function automatic int trk_m_w(input int reg_aw);
    return reg_aw + 2;
  endfunction

  function automatic int trk_a_w(input int reg_aw);
    return reg_aw + 3;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_br_fwd_match.sv
// br_fwd_match: forwarding lookup for one branch source operand.
// Compares the operand address against the A and M tracker entries.
//   x        in   source register address
//   en       in   operand is actually read by the instruction in B
//   a_ent    in   A tracker entry {is_load, rd, regwen, vld}
//   m_ent    in   M tracker entry {rd, regwen, vld}
//   need     out  operand has an in-flight writer and must be forwarded
//   src      out  SRC_A or SRC_M; the youngest writer (A) wins
//   unready  out  the winning writer is a load still in A (no data yet)
module br_fwd_match
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0]          x,
  input  logic                       en,
  input  logic [trk_a_w(REG_AW)-1:0] a_ent,
  input  logic [trk_m_w(REG_AW)-1:0] m_ent,
  output logic                       need,
  output logic                       src,
  output logic                       unready
);

  logic x_nz;
  logic a_hit;
  logic m_hit;

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  assign x_nz  = (x != '0);
  assign a_hit = en && x_nz && a_ent[TRK_VLD] && a_ent[TRK_REGWEN] &&
                 (a_ent[TRK_RD +: REG_AW] == x);
  assign m_hit = en && x_nz && m_ent[TRK_VLD] && m_ent[TRK_REGWEN] &&
                 (m_ent[TRK_RD +: REG_AW] == x);

  assign need    = a_hit || m_hit;
  assign src     = a_hit ? SRC_A : SRC_M;
  assign unready = a_hit && a_ent[REG_AW + 2];

endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: branch-operand forwarding select and stall generator.
// Tracks the two older in-flight writers (A: ALU result, M: dmem/writeback)
// and produces the br_haz mux select plus a stall for the branch in B.
// Only one operand can be forwarded per cycle; two forwards or a load still
// in A force a stall, which bubbles A so the producers drain.
// Optional feature macro: BR_HAZ_PERF_EN enables the saturating stall_cycles
// counter; without it stall_cycles is tied to 0.
// Ports:
//   clk, rst (async active-low)
//   b_valid, b_is_branch, b_rs1, b_rs2, b_uses_rs2  - branch in B
//   b_regwen, b_rd, b_is_load                        - B as a writer into A
//   flush        - kill B; B is not captured into A, FSM returns to RUN
//   br_haz       - 0 none, 1 alu->a, 2 alu->b, 3 dmem->a, 4 dmem->b
//   stall        - hold PC/IF/B this cycle
//   stall_cycles - perf count of stall cycles
//   dbg_state    - {fsm state, hold_cnt}
// Handshake: there is no valid/ready pair; stall is the only backpressure
// and is combinational, so upstream must hold B in the same cycle it is seen.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_valid,
  input  logic              b_is_branch,
  input  logic [REG_AW-1:0] b_rs1,
  input  logic [REG_AW-1:0] b_rs2,
  input  logic              b_uses_rs2,
  input  logic              b_regwen,
  input  logic [REG_AW-1:0] b_rd,
  input  logic              b_is_load,
  input  logic              flush,
  output logic [2:0]        br_haz,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [2:0]        dbg_state
);

  localparam int AW_T = trk_a_w(REG_AW);
  localparam int MW_T = trk_m_w(REG_AW);

  logic [AW_T-1:0] a_q, a_d;
  logic [MW_T-1:0] m_q, m_d;

  fsm_state_e state_q;
  logic [1:0] hold_cnt_q;

  logic need1, src1, unrdy1;
  logic need2, src2, unrdy2;

  br_fwd_match #(.REG_AW(REG_AW)) u_match_rs1 (
    .x       (b_rs1),
    .en      (1'b1),
    .a_ent   (a_q),
    .m_ent   (m_q),
    .need    (need1),
    .src     (src1),
    .unready (unrdy1)
  );

  br_fwd_match #(.REG_AW(REG_AW)) u_match_rs2 (
    .x       (b_rs2),
    .en      (b_uses_rs2),
    .a_ent   (a_q),
    .m_ent   (m_q),
    .need    (need2),
    .src     (src2),
    .unready (unrdy2)
  );

  // Select and stall are combinational so the mux sees them in the same cycle.
  always_comb begin
    br_haz = BR_HAZ_NONE;
    stall  = 1'b0;
    if (b_valid && b_is_branch) begin
      if (unrdy1 || unrdy2) begin
        stall = 1'b1;
      end else if (need1 && need2) begin
        stall = 1'b1;
      end else if (need1) begin
        br_haz = (src1 == SRC_M) ? BR_HAZ_DMEM_A : BR_HAZ_ALU_A;
      end else if (need2) begin
        br_haz = (src2 == SRC_M) ? BR_HAZ_DMEM_B : BR_HAZ_ALU_B;
      end
    end
  end

  // A captures B unless it is stalled or flushed; M always inherits A,
  // dropping the is_load flag.
  always_comb begin
    m_d = a_q[MW_T-1:0];
    a_d = '0;
    if (b_valid && !stall && !flush) begin
      a_d[TRK_VLD]            = 1'b1;
      a_d[TRK_REGWEN]         = b_regwen;
      a_d[TRK_RD +: REG_AW]   = b_rd;
      a_d[REG_AW + 2]         = b_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= a_d;
      m_q <= m_d;
    end
  end

  // RUN/HOLD stall sequencer; hold_cnt counts consecutive stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= 2'd0;
    end else if (flush) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 2'd1;
          end
        end
        ST_HOLD: begin
          if (stall) begin
            if (hold_cnt_q != 2'd3) hold_cnt_q <= hold_cnt_q + 2'd1;
          end else begin
            state_q    <= ST_RUN;
            hold_cnt_q <= 2'd0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          hold_cnt_q <= 2'd0;
        end
      endcase
    end
  end

  assign dbg_state = {state_q, hold_cnt_q};

  hold_cnt_legal: assert property (@(posedge clk) disable iff (!rst)
                                   hold_cnt_q <= HOLD_CNT_MAX);

`ifdef BR_HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles_q <= '0;
    else      stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_valid;
  logic        b_is_branch;
  logic [4:0]  b_rs1;
  logic [4:0]  b_rs2;
  logic        b_uses_rs2;
  logic        b_regwen;
  logic [4:0]  b_rd;
  logic        b_is_load;
  logic        flush;
  logic [2:0]  br_haz;
  logic        stall;
  logic [31:0] stall_cycles;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  branch_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_valid      (b_valid),
    .b_is_branch  (b_is_branch),
    .b_rs1        (b_rs1),
    .b_rs2        (b_rs2),
    .b_uses_rs2   (b_uses_rs2),
    .b_regwen     (b_regwen),
    .b_rd         (b_rd),
    .b_is_load    (b_is_load),
    .flush        (flush),
    .br_haz       (br_haz),
    .stall        (stall),
    .stall_cycles (stall_cycles),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic b_idle();
    b_valid = 1'b0; b_is_branch = 1'b0; b_rs1 = '0; b_rs2 = '0;
    b_uses_rs2 = 1'b0; b_regwen = 1'b0; b_rd = '0; b_is_load = 1'b0;
  endtask

  task automatic b_alu(input logic [4:0] rd);
    b_idle();
    b_valid = 1'b1; b_regwen = 1'b1; b_rd = rd;
  endtask

  task automatic b_load(input logic [4:0] rd);
    b_alu(rd);
    b_is_load = 1'b1;
  endtask

  task automatic b_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    b_idle();
    b_valid = 1'b1; b_is_branch = 1'b1; b_rs1 = rs1; b_rs2 = rs2;
    b_uses_rs2 = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    b_idle();
    step();
    rst = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] haz,
                            input logic stl);
    #1;
    check_eq({tag, "_br_haz"}, 32'(br_haz), 32'(haz));
    check_eq({tag, "_stall"},  32'(stall),  32'(stl));
  endtask

  logic [31:0] exp_perf;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    b_idle();
    #1;
    check_eq("reset_dbg", 32'(dbg_state), 32'd0);
    check_eq("reset_perf", stall_cycles, 32'd0);
    b_branch(5'd5, 5'd6);
    expect_out("reset_branch", 3'd0, 1'b0);

    // 1: ALU writer in A feeds rs1
    do_reset();
    b_alu(5'd5); step();
    b_branch(5'd5, 5'd6);
    expect_out("t1_alu_a", 3'd1, 1'b0);

    // 2: load in A, then forward from M on rs2
    do_reset();
    b_load(5'd7); step();
    b_branch(5'd1, 5'd7);
    expect_out("t2_load_stall", 3'd0, 1'b1);
    step();
    check_eq("t2_dbg_hold", 32'(dbg_state), 32'h5);
    expect_out("t2_dmem_b", 3'd4, 1'b0);
    step();
    check_eq("t2_dbg_run", 32'(dbg_state), 32'h0);

    // 3: both operands need forwarding -> one stall, then dmem->a
    do_reset();
    b_alu(5'd4); step();
    b_alu(5'd3); step();
    b_branch(5'd3, 5'd4);
    expect_out("t3_double_fwd", 3'd0, 1'b1);
    step();
    expect_out("t3_dmem_a", 3'd3, 1'b0);

    // 4: x0 never matches
    do_reset();
    b_alu(5'd0); step();
    b_branch(5'd0, 5'd6);
    expect_out("t4_x0", 3'd0, 1'b0);

    // 5: same rd in A and M, A wins
    do_reset();
    b_alu(5'd9); step();
    b_alu(5'd9); step();
    b_branch(5'd9, 5'd2);
    expect_out("t5_a_priority", 3'd1, 1'b0);

    // rs2 ignored when not read; non-branch never forwards/stalls
    do_reset();
    b_alu(5'd6); step();
    b_branch(5'd1, 5'd6);
    expect_out("rs2_used", 3'd2, 1'b0);
    b_uses_rs2 = 1'b0;
    expect_out("rs2_unused", 3'd0, 1'b0);
    b_alu(5'd6);
    b_rs1 = 5'd6;
    expect_out("non_branch", 3'd0, 1'b0);

    // flush keeps B out of A
    do_reset();
    b_alu(5'd5); flush = 1'b1; step();
    flush = 1'b0;
    b_branch(5'd5, 5'd6);
    expect_out("flush_no_capture", 3'd0, 1'b0);

    // 6a: flush during the load stall
    do_reset();
    b_load(5'd7); step();
    b_branch(5'd1, 5'd7); flush = 1'b1;
    expect_out("t6_flush_stall", 3'd0, 1'b1);
    step();
    flush = 1'b0;
    check_eq("t6_flush_dbg", 32'(dbg_state), 32'h0);
    expect_out("t6_after_flush", 3'd4, 1'b0);

    // 6b: reset mid-stall clears outputs immediately
    do_reset();
    b_load(5'd7); step();
    b_branch(5'd1, 5'd7);
    expect_out("t6_pre_rst", 3'd0, 1'b1);
    rst = 1'b0;
    expect_out("t6_async_rst", 3'd0, 1'b0);
    check_eq("t6_rst_perf", stall_cycles, 32'd0);

    // worst case: two consecutive stalls, then perf count
    do_reset();
    b_load(5'd7); step();
    b_branch(5'd7, 5'd7);
    expect_out("ws_stall0", 3'd0, 1'b1);
    step();
    check_eq("ws_dbg1", 32'(dbg_state), 32'h5);
    expect_out("ws_stall1", 3'd0, 1'b1);
    step();
    check_eq("ws_dbg2", 32'(dbg_state), 32'h6);
    expect_out("ws_free", 3'd0, 1'b0);
    step();
    check_eq("ws_dbg3", 32'(dbg_state), 32'h0);
`ifdef BR_HAZ_PERF_EN
    exp_perf = 32'd2;
`else
    exp_perf = 32'd0;
`endif
    check_eq("perf_count", stall_cycles, exp_perf);

    b_idle();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
